keypad_key_emulator: RTL

- Responder end of the 3-column x 4-row keypad scan interface: watches the column strobes the keypad scanner drives and drives the row lines back, as if a physical key were held down.
- Accepts a queued stream of 4-bit note codes and "presses" the key for each code for a fixed hold time, then releases it for a fixed gap.
- Used for auto-play / demo songs and for self-test of the keypad-to-speaker path; it sits between the song sequencer and the scanner's row inputs.

---
 rtl/keypad_key_emulator.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/keypad_key_emulator.sv
// Keypad key emulator: replays queued note codes as held keys on the scanner's row lines.
// Build option: define KEYPAD2_LAYOUT_EN for the second keypad layout (columns 0 and 1 swapped per row).
module keypad_key_emulator #(
    parameter int HOLD_CYCLES = 400000,
    parameter int GAP_CYCLES  = 400000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [2:0]                    col,
    input  logic [3:0]                    note_in,
    input  logic                          note_valid,
    output logic                          note_ready,
    input  logic                          flush,
    output logic [3:0]                    row,
    output logic                          busy,
    output logic [3:0]                    active_note,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [3:0]         active_note_reg;
    logic [3:0]         row_reg, row_next;
    logic               fifo_empty, fifo_full;
    logic               push, pop, note_clear;

    // Constant note -> (row, column, is-key) lookup, one entry per 4-bit code.
    logic [15:0][3:0]   map_row;
    logic [15:0][2:0]   map_col;
    logic [15:0]        map_key;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_map
            if (gi >= 1 && gi <= 12) begin : g_key
                localparam int K = 12 - gi;
`ifdef KEYPAD2_LAYOUT_EN
                localparam int COL_IDX = (K % 3 == 0) ? 1 : (K % 3 == 1) ? 0 : 2;
`else
                localparam int COL_IDX = K % 3;
`endif
                assign map_row[gi] = 4'b1000 >> (K / 3);
                assign map_col[gi] = 3'b100 >> COL_IDX;
                assign map_key[gi] = 1'b1;
            end else begin : g_rest
                assign map_row[gi] = 4'b0000;
                assign map_col[gi] = 3'b000;
                assign map_key[gi] = 1'b0;
            end
        end
    endgenerate

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_LEVEL);
    // A flush in the same cycle drops the incoming note.
    assign push       = note_valid && !fifo_full && !flush;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        note_clear = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_PRESS;
                    cnt_next   = '0;
                end
            end
            ST_PRESS: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    note_clear = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                note_clear = 1'b1;
            end
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            pop        = 1'b0;
            note_clear = 1'b1;
        end
    end

    // The key only answers when the scanner strobes exactly its column.
    always_comb begin
        row_next = 4'b0000;
        if (!flush && state_reg == ST_PRESS && map_key[active_note_reg]
                && col == map_col[active_note_reg]) begin
            row_next = map_row[active_note_reg];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= note_in;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            active_note_reg <= 4'hF;
            row_reg         <= 4'b0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            row_reg   <= row_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
            if (pop) begin
                active_note_reg <= fifo_mem[rd_ptr_reg];
            end else if (note_clear) begin
                active_note_reg <= 4'hF;
            end
        end
    end

    assign note_ready  = !fifo_full;
    assign busy        = (state_reg != ST_IDLE) || !fifo_empty;
    assign active_note = active_note_reg;
    assign fifo_level  = count_reg;
    assign row         = row_reg;

endmodule
